// File: rtl/irq_responder.sv
// irq_responder: CPU-side end of the interrupt handshake.
//
// Detects a rising edge on irq_req, redirects the PC to the interrupt vector at the
// next instruction boundary, saves the return address, and restores the PC on a
// return-from-interrupt. After the return, s_finished is held high for FINISH_CYCLES
// cycles so the controller can see that service has ended.
//
// Optional build macro IRQ_FLAGS_SAVE_EN: when defined, the ALU flags {z,c} are saved
// on vector entry and handed back (flags_load pulse) on return. When undefined, no
// flag register is built and flags_load/flags_out are tied low.
//
// Reset is synchronous and active-high.

module irq_responder #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned FINISH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_vector,
    input  logic              instr_boundary,
    input  logic [ADDR_W-1:0] pc_return,
    input  logic              reti,
    input  logic [1:0]        flags_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              s_finished,
    output logic              in_service,
    output logic              spurious_reti,
    output logic              flags_load,
    output logic [1:0]        flags_out
);

    // Counter reload value: FINISH lasts FINISH_CYCLES cycles (counts FINISH_CYCLES-1 .. 0).
    localparam logic [3:0] CntInit = 4'(FINISH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StService,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic                irq_q;
    logic [ADDR_W-1:0]   vec_q, vec_d;
    logic [ADDR_W-1:0]   ret_q, ret_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_vec_q, pend_vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                fin_q, fin_d;
    logic                spur_q, spur_d;
    logic                pc_load_q;

    logic                irq_edge;
    logic                ret_req;
    logic                flags_capture;
    logic                flags_restore;

    assign irq_edge = irq_req & ~irq_q;
    assign ret_req  = reti & instr_boundary;

    // Edge-detect register for irq_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_req;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            ret_q      <= '0;
            pend_q     <= 1'b0;
            pend_vec_q <= '0;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            spur_q     <= 1'b0;
            pc_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            ret_q      <= ret_d;
            pend_q     <= pend_d;
            pend_vec_q <= pend_vec_d;
            cnt_q      <= cnt_d;
            fin_q      <= fin_d;
            spur_q     <= spur_d;
            pc_load_q  <= pc_load;
        end
    end

    // Next-state logic and PC redirect outputs.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        ret_d         = ret_q;
        pend_d        = pend_q;
        pend_vec_d    = pend_vec_q;
        cnt_d         = cnt_q;
        fin_d         = fin_q;
        spur_d        = spur_q;
        pc_load       = 1'b0;
        pc_target     = '0;
        flags_capture = 1'b0;
        flags_restore = 1'b0;

        // A request arriving while busy is parked one deep; a later one overwrites it.
        if (irq_edge && (state_q != StIdle)) begin
            pend_d     = 1'b1;
            pend_vec_d = irq_vector;
        end

        case (state_q)
            StIdle: begin
                if (irq_edge) begin
                    vec_d   = irq_vector;
                    state_d = StPending;
                end
                if (ret_req) begin
                    spur_d = 1'b1;
                end
            end

            StPending: begin
                if (ret_req) begin
                    spur_d = 1'b1;
                end
                if (instr_boundary) begin
                    pc_load       = 1'b1;
                    pc_target     = vec_q;
                    ret_d         = pc_return;
                    flags_capture = 1'b1;
                    state_d       = StService;
                end
            end

            StService: begin
                // Skip a return right after the vector load so pc_load never fires twice in a row.
                if (ret_req && !pc_load_q) begin
                    pc_load       = 1'b1;
                    pc_target     = ret_q;
                    fin_d         = 1'b1;
                    cnt_d         = CntInit;
                    flags_restore = 1'b1;
                    state_d       = StFinish;
                end
            end

            StFinish: begin
                if (cnt_q == 4'd0) begin
                    fin_d = 1'b0;
                    // An edge in this very cycle is newer than anything parked, so it wins.
                    if (pend_q || irq_edge) begin
                        vec_d   = irq_edge ? irq_vector : pend_vec_q;
                        pend_d  = 1'b0;
                        state_d = StPending;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs; in_service falls together with s_finished on leaving FINISH.
    always_comb begin
        s_finished    = fin_q;
        in_service    = (state_q == StService) || (state_q == StFinish);
        spurious_reti = spur_q;
    end

`ifdef IRQ_FLAGS_SAVE_EN
    logic [1:0] flags_q;

    // Saved ALU flags, captured on vector entry and held until the next entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 2'b00;
        end else if (flags_capture) begin
            flags_q <= flags_in;
        end
    end

    assign flags_out  = flags_q;
    assign flags_load = flags_restore;
`else
    logic unused_flags;

    assign unused_flags = ^{flags_in, flags_capture, flags_restore};
    assign flags_out    = 2'b00;
    assign flags_load   = 1'b0;
`endif

endmodule

// File: tb/tb_irq_responder.sv
// Directed, table-driven bench for irq_responder (ADDR_W=10, FINISH_CYCLES=2).
// Inputs change on the falling edge; outputs are compared 2 ns later, before the next
// rising edge, so each row describes one clock cycle.

module tb_irq_responder;

    logic       clk;
    logic       reset;
    logic       irq_req;
    logic [9:0] irq_vector;
    logic       instr_boundary;
    logic [9:0] pc_return;
    logic       reti;
    logic [1:0] flags_in;
    logic       pc_load;
    logic [9:0] pc_target;
    logic       s_finished;
    logic       in_service;
    logic       spurious_reti;
    logic       flags_load;
    logic [1:0] flags_out;

    int n_vec = 0;
    int n_bad = 0;

    irq_responder #(
        .ADDR_W        (10),
        .FINISH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .instr_boundary (instr_boundary),
        .pc_return      (pc_return),
        .reti           (reti),
        .flags_in       (flags_in),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .s_finished     (s_finished),
        .in_service     (in_service),
        .spurious_reti  (spurious_reti),
        .flags_load     (flags_load),
        .flags_out      (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       irq;
        logic [9:0] vec;
        logic       bnd;
        logic [9:0] ret;
        logic       rti;
        logic       e_load;
        logic [9:0] e_tgt;
        logic       e_fin;
        logic       e_svc;
        logic       e_spur;
    } row_t;

    row_t rows[$];

    task automatic add(input logic irq, input logic [9:0] vec, input logic bnd,
                       input logic [9:0] ret, input logic rti, input logic e_load,
                       input logic [9:0] e_tgt, input logic e_fin, input logic e_svc,
                       input logic e_spur);
        row_t r;
        r.irq = irq; r.vec = vec; r.bnd = bnd; r.ret = ret; r.rti = rti;
        r.e_load = e_load; r.e_tgt = e_tgt; r.e_fin = e_fin; r.e_svc = e_svc;
        r.e_spur = e_spur;
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and settle before comparing.
    task automatic drive(input logic irq, input logic [9:0] vec, input logic bnd,
                         input logic [9:0] ret, input logic rti);
        @(negedge clk);
        irq_req        = irq;
        irq_vector     = vec;
        instr_boundary = bnd;
        pc_return      = ret;
        reti           = rti;
        #2;
    endtask

    logic [1:0] exp_flags_out;
    logic       exp_flags_load;

    initial begin
        reset = 1'b1; irq_req = 1'b0; irq_vector = '0; instr_boundary = 1'b0;
        pc_return = '0; reti = 1'b0; flags_in = 2'b00;

        //   irq vec     bnd ret     rti  load tgt     fin svc spur
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 0, 0, 0);  // 0 reset state
        add(1, 10'h012, 1, 10'h05A, 0,   0, 10'h000, 0, 0, 0);  // 1 edge in IDLE, no redirect
        add(1, 10'h012, 1, 10'h05A, 0,   1, 10'h012, 0, 0, 0);  // 2 vector load
        add(1, 10'h000, 1, 10'h000, 0,   0, 10'h000, 0, 1, 0);  // 3 SERVICE
        add(0, 10'h000, 1, 10'h000, 1,   1, 10'h05A, 0, 1, 0);  // 4 return
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 5 FINISH 1
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 6 FINISH 2
        add(0, 10'h000, 1, 10'h000, 0,   0, 10'h000, 0, 0, 0);  // 7 back in IDLE
        add(1, 10'h100, 0, 10'h000, 0,   0, 10'h000, 0, 0, 0);  // 8 edge
        add(1, 10'h100, 0, 10'h000, 0,   0, 10'h000, 0, 0, 0);  // 9 waiting boundary
        add(1, 10'h100, 1, 10'h0AA, 0,   1, 10'h100, 0, 0, 0);  // 10 vector load
        add(0, 10'h000, 1, 10'h000, 1,   0, 10'h000, 0, 1, 0);  // 11 back-to-back reti held off
        add(1, 10'h3FB, 0, 10'h000, 1,   0, 10'h000, 0, 1, 0);  // 12 reti w/o boundary; edge parked
        add(1, 10'h000, 1, 10'h000, 1,   1, 10'h0AA, 0, 1, 0);  // 13 return
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 14 FINISH 1
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 15 FINISH 2 -> PENDING
        add(0, 10'h000, 1, 10'h123, 0,   1, 10'h3FB, 0, 0, 0);  // 16 parked vector taken
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 0, 1, 0);  // 17 SERVICE
        add(1, 10'h055, 1, 10'h000, 1,   1, 10'h123, 0, 1, 0);  // 18 return + edge together
        add(1, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 19 FINISH 1
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 20 FINISH 2 -> PENDING
        add(0, 10'h000, 0, 10'h000, 1,   0, 10'h000, 0, 0, 0);  // 21 PENDING, no boundary
        add(0, 10'h000, 1, 10'h200, 0,   1, 10'h055, 0, 0, 0);  // 22 vector load
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 0, 1, 0);  // 23 SERVICE
        add(0, 10'h000, 1, 10'h000, 1,   1, 10'h200, 0, 1, 0);  // 24 return
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 25 FINISH 1
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 1, 1, 0);  // 26 FINISH 2
        add(0, 10'h000, 1, 10'h000, 1,   0, 10'h000, 0, 0, 0);  // 27 spurious reti in IDLE
        add(0, 10'h000, 0, 10'h000, 0,   0, 10'h000, 0, 0, 1);  // 28 sticky
        add(0, 10'h000, 1, 10'h000, 0,   0, 10'h000, 0, 0, 1);  // 29 sticky

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].irq, rows[i].vec, rows[i].bnd, rows[i].ret, rows[i].rti);
            chk($sformatf("row%0d pc_load", i), 16'(pc_load), 16'(rows[i].e_load));
            if (rows[i].e_load)
                chk($sformatf("row%0d pc_target", i), 16'(pc_target), 16'(rows[i].e_tgt));
            chk($sformatf("row%0d s_finished", i), 16'(s_finished), 16'(rows[i].e_fin));
            chk($sformatf("row%0d in_service", i), 16'(in_service), 16'(rows[i].e_svc));
            chk($sformatf("row%0d spurious", i), 16'(spurious_reti), 16'(rows[i].e_spur));
        end

`ifdef IRQ_FLAGS_SAVE_EN
        exp_flags_out  = 2'b10;
        exp_flags_load = 1'b1;
`else
        exp_flags_out  = 2'b00;
        exp_flags_load = 1'b0;
`endif

        // Boundary held low for 5 cycles after the edge: redirect waits for it.
        drive(1, 10'h2C0, 0, 10'h000, 0);
        chk("slow edge pc_load", 16'(pc_load), 16'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 10'h2C0, 0, 10'h000, 0);
            chk($sformatf("slow wait%0d pc_load", k), 16'(pc_load), 16'd0);
        end
        flags_in = 2'b10;
        drive(1, 10'h2C0, 1, 10'h0F0, 0);
        chk("slow load pc_load", 16'(pc_load), 16'd1);
        chk("slow load pc_target", 16'(pc_target), 16'h2C0);
        flags_in = 2'b01;
        drive(0, 10'h000, 0, 10'h000, 0);
        chk("svc in_service", 16'(in_service), 16'd1);
        chk("svc flags_out", 16'(flags_out), 16'(exp_flags_out));
        drive(0, 10'h000, 1, 10'h000, 1);
        chk("ret pc_load", 16'(pc_load), 16'd1);
        chk("ret pc_target", 16'(pc_target), 16'h0F0);
        chk("ret flags_load", 16'(flags_load), 16'(exp_flags_load));

        // Reset asserted while in FINISH.
        drive(0, 10'h000, 0, 10'h000, 0);
        chk("finish s_finished", 16'(s_finished), 16'd1);
        reset = 1'b1;
        drive(0, 10'h000, 1, 10'h000, 0);
        reset = 1'b0;
        #1;
        chk("post-reset s_finished", 16'(s_finished), 16'd0);
        chk("post-reset in_service", 16'(in_service), 16'd0);
        chk("post-reset spurious", 16'(spurious_reti), 16'd0);
        chk("post-reset pc_load", 16'(pc_load), 16'd0);
        chk("post-reset flags_out", 16'(flags_out), 16'd0);

        // Edge together with a boundary in IDLE: redirect one cycle later.
        drive(1, 10'h011, 1, 10'h033, 0);
        chk("idle edge+bnd pc_load", 16'(pc_load), 16'd0);
        drive(1, 10'h011, 1, 10'h033, 0);
        chk("min latency pc_load", 16'(pc_load), 16'd1);
        chk("min latency pc_target", 16'(pc_target), 16'h011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
